// File: rtl/crc5_serial_unit.sv
// Bit-serial CRC-5 (x^5+x^2+1) engine. In generate mode it forwards data and appends the CRC.
// In check mode it forwards data plus CRC and reports whether the residue matched.
module crc5_serial_unit #(
  parameter logic [4:0] POLY     = 5'b00101,
  parameter logic [4:0] INIT     = 5'b11111,
  parameter bit         INVERT   = 1'b1,
  parameter logic [4:0] RESIDUE  = 5'b01100,
  parameter int         MAX_BITS = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       mode_chk,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_crc,
  input  logic       out_ready,
  output logic [4:0] crc_o,
  output logic       crc_ok,
  output logic       len_err,
  output logic       busy,
  output logic       done
);

  // Handshake: a bit moves on either side only in a cycle where valid && ready are both high.
  // The output register holds out_bit/out_crc steady until out_ready accepts it.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_APPEND = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0] state;
  logic [4:0] lfsr;
  logic [4:0] lfsr_next;
  logic [4:0] final_crc;
  logic [6:0] cnt;
  logic [2:0] idx;
  logic       mode_q;
  logic       out_free;
  logic       accept;
  logic       frame_end;
  logic       fb;

  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == S_DATA) && out_free;
  assign accept    = in_valid && in_ready;
  assign fb        = lfsr[4] ^ in_bit;
  assign lfsr_next = {lfsr[3:0], 1'b0} ^ ({5{fb}} & POLY);
  assign final_crc = INVERT ? ~lfsr_next : lfsr_next;
  // A frame ends on in_last or on the MAX_BITS-th accepted bit, whichever comes first.
  assign frame_end = accept && (in_last || (cnt == 7'(MAX_BITS - 1)));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lfsr    <= INIT;
      cnt     <= '0;
      idx     <= '0;
      mode_q  <= 1'b0;
      crc_o   <= '0;
      crc_ok  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            lfsr    <= INIT;
            cnt     <= '0;
            len_err <= 1'b0;
            crc_o   <= '0;
            crc_ok  <= 1'b0;
            mode_q  <= mode_chk;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            lfsr <= lfsr_next;
            if (cnt != 7'h7f) cnt <= cnt + 7'd1;
            if (frame_end) begin
              if (!in_last) len_err <= 1'b1;
              if (mode_q) begin
                crc_ok <= (lfsr_next == RESIDUE);
                state  <= S_DONE;
              end else begin
                crc_o <= final_crc;
                idx   <= 3'd4;
                state <= S_APPEND;
              end
            end
          end
        end
        S_APPEND: begin
          if (out_free) begin
            if (idx == 3'd0) state <= S_DONE;
            else idx <= idx - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register: forwarded data, then appended CRC bits MSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_crc   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_bit   <= in_bit;
      out_crc   <= 1'b0;
    end else if ((state == S_APPEND) && out_free) begin
      out_valid <= 1'b1;
      out_bit   <= crc_o[idx];
      out_crc   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_crc5_serial_unit.sv
// Bench for crc5_serial_unit: table-driven frames, hand corner sequences and random frames
// checked against a polynomial-division reference.
module tb_crc5_serial_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, mode_chk, in_valid, in_bit, in_last;
  logic       in_ready, out_valid, out_bit, out_crc, out_ready;
  logic [4:0] crc_o;
  logic       crc_ok, len_err, busy, done;

  crc5_serial_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_chk(mode_chk),
    .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_bit(out_bit), .out_crc(out_crc), .out_ready(out_ready),
    .crc_o(crc_o), .crc_ok(crc_ok), .len_err(len_err), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           chk;
    int           n;
    logic [127:0] bits;
    bit           use_last;
    bit           has_exp;
    logic [4:0]   exp_crc;
    bit           exp_ok;
  } vec_t;

  localparam logic [4:0] M_INIT    = 5'b11111;
  localparam logic [4:0] M_RESIDUE = 5'b01100;

  int         n_total = 0;
  int         n_bad   = 0;
  int         done_total = 0;
  int         crc_total  = 0;
  int         block_cnt  = 0;
  int         stall_at   = -1;
  bit         rand_ready = 1'b0;
  bit         rand_valid = 1'b0;
  logic [1:0] got_q[$];
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Remainder of (INIT*x^n + M(x)*x^5) mod (x^5+x^2+1), first message bit = highest power.
  function automatic logic [4:0] crc_rem(input logic [127:0] bits, input int n);
    logic [135:0] d;
    d = '0;
    for (int k = 0; k < 5; k++) d[n + k] = M_INIT[k];
    for (int i = 0; i < n; i++) d[n + 4 - i] = d[n + 4 - i] ^ bits[i];
    for (int p = n + 4; p >= 5; p--)
      if (d[p]) d[p - 5 +: 6] = d[p - 5 +: 6] ^ 6'b100101;
    return d[4:0];
  endfunction

  // Output side: choose out_ready for the coming edge, then log what that edge transfers.
  always @(negedge clk) begin
    if (block_cnt > 0) begin
      out_ready = 1'b0;
      block_cnt--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    if (!rst && out_valid && out_ready) begin
      got_q.push_back({out_crc, out_bit});
      if (out_crc) begin
        crc_total++;
        if (crc_total == stall_at) block_cnt = 3;
      end
    end
    if (done) done_total++;
  end

  task automatic start_frame(input bit chk);
    @(posedge clk); #1;
    start_i  = 1'b1;
    mode_chk = chk;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  task automatic feed(input int n_send, input logic [127:0] bits, input bit use_last,
                      input int start_at, output int acc);
    int  budget;
    bit  took;
    acc = 0;
    budget = 0;
    while (acc < n_send && acc < 64 && budget < 2000) begin
      in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit   = bits[acc];
      in_last  = use_last && (acc == n_send - 1);
      start_i  = (acc == start_at);
      @(negedge clk); #1;
      took = in_ready && in_valid;
      @(posedge clk); #1;
      if (took) acc++;
      budget++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bit   = 1'b0;
    start_i  = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input int st_at, input int start_pulse);
    int         acc, gb, db, to, exp_n, bad_i;
    bit         exp_len;
    logic [4:0] rem, exp_crc;
    exp_n   = (v.n > 64) ? 64 : v.n;
    exp_len = (v.n >= 64) && !(v.use_last && v.n == 64);
    gb = got_q.size();
    db = done_total;
    stall_at = (st_at < 0) ? -1 : crc_total + st_at;
    start_frame(v.chk);
    check("len_clr", len_err, 0);
    feed(v.n, v.bits, v.use_last, start_pulse, acc);
    check("accepted", acc, exp_n);
    to = 0;
    while (done_total == db && to < 300) begin @(negedge clk); #2; to++; end
    check("done_seen", done_total != db, 1);
    to = 0;
    while (out_valid && to < 300) begin @(negedge clk); #2; to++; end
    repeat (3) @(negedge clk);
    #2;
    check("done_once", done_total - db, 1);
    check("busy_idle", busy, 0);
    rem     = crc_rem(v.bits, exp_n);
    exp_crc = ~rem;
    exp_q.delete();
    for (int i = 0; i < exp_n; i++) exp_q.push_back({1'b0, v.bits[i]});
    if (!v.chk) for (int k = 4; k >= 0; k--) exp_q.push_back({1'b1, exp_crc[k]});
    check("stream_len", got_q.size() - gb, exp_q.size());
    bad_i = -1;
    for (int i = 0; i < exp_q.size() && gb + i < got_q.size(); i++)
      if (got_q[gb + i] !== exp_q[i] && bad_i < 0) bad_i = i;
    check("stream_first_bad_idx", bad_i, -1);
    if (!v.chk) check("crc_o", crc_o, exp_crc);
    check("crc_ok", crc_ok, v.chk && (rem == M_RESIDUE));
    check("len_err", len_err, exp_len);
    if (v.has_exp) begin
      if (!v.chk) check("crc_hand", crc_o, v.exp_crc);
      check("ok_hand", crc_ok, v.exp_ok);
    end
    stall_at = -1;
  endtask

  initial begin
    vec_t         tbl[4];
    vec_t         v;
    int           acc, db, k;
    logic [127:0] b;
    logic [4:0]   c;

    tbl[0] = '{chk: 0, n: 11, bits: 128'h0,    use_last: 1, has_exp: 1, exp_crc: 5'b01000, exp_ok: 0};
    tbl[1] = '{chk: 1, n: 16, bits: 128'h1000, use_last: 1, has_exp: 1, exp_crc: 5'b00000, exp_ok: 1};
    tbl[2] = '{chk: 1, n: 16, bits: 128'h1800, use_last: 1, has_exp: 1, exp_crc: 5'b00000, exp_ok: 0};
    tbl[3] = '{chk: 0, n: 8,  bits: 128'hA5,   use_last: 1, has_exp: 0, exp_crc: 5'b00000, exp_ok: 0};

    rst = 1'b1; start_i = 1'b0; mode_chk = 1'b0;
    in_valid = 1'b0; in_bit = 1'b0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_crc_o", crc_o, 0);
    check("rst_flags", {crc_ok, len_err}, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_frame(tbl[i], -1, -1);

    // out_ready held low for 3 cycles after the second CRC bit is taken
    run_frame(tbl[0], 2, -1);

    // 70 bits offered with no in_last: forced end after the 64th bit
    v = '{chk: 0, n: 70, bits: {$urandom, $urandom, $urandom, $urandom}, use_last: 0,
          has_exp: 0, exp_crc: 5'b0, exp_ok: 0};
    run_frame(v, -1, -1);
    run_frame(tbl[3], -1, -1);
    v.use_last = 1'b1;
    v.n = 64;
    run_frame(v, -1, -1);

    // start_i mid-frame and on the end cycle must be ignored
    v = '{chk: 0, n: 10, bits: 128'h2d3, use_last: 1, has_exp: 0, exp_crc: 5'b0, exp_ok: 0};
    run_frame(v, -1, 4);
    run_frame(v, -1, 9);

    // reset while the CRC is being appended
    db = done_total;
    start_frame(1'b0);
    feed(5, 128'h13, 1'b1, -1, acc);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_crc_o", crc_o, 0);
    check("arst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    check("arst_no_done", done_total - db, 0);
    run_frame(tbl[0], -1, -1);

    // random frames with random valid/ready gaps
    rand_ready = 1'b1;
    rand_valid = 1'b1;
    for (int f = 0; f < 25; f++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      v = '{chk: $urandom_range(0, 1), n: $urandom_range(1, 24), bits: b, use_last: 1,
            has_exp: 0, exp_crc: 5'b0, exp_ok: 0};
      if (v.chk && $urandom_range(0, 1)) begin
        k = $urandom_range(1, 19);
        c = ~crc_rem(b, k);
        for (int j = 0; j < 5; j++) v.bits[k + j] = c[4 - j];
        v.n = k + 5;
      end
      run_frame(v, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
